// File: rtl/slt_pkg.sv
// Shared types and helpers for the multi-cycle set-less-than unit.
package slt_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic ALUC_SLT  = 1'b1;
  localparam logic ALUC_SLTU = 1'b0;

  function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/slt_chunk_cmp.sv
// Combinational unsigned comparator for one CHUNK-bit slice.
module slt_chunk_cmp #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             lt,
  output logic             eq
);

  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/slt_seq.sv
// Multi-cycle slt/sltu: compares CHUNK bits per clock, most-significant chunk first,
// with optional early exit on the first differing chunk.
module slt_seq
  import slt_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned CHUNK      = 8,
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             aluc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] c,
  output logic             carry,
  output logic             negative,
  output logic             equal
);

  localparam int unsigned NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned SW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  if ((WIDTH % CHUNK) != 0 || NCHUNK < 1) begin : g_bad_params
    $error("slt_seq: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             aluc_q;
  logic [IW-1:0]    idx_q;
  logic             dec_q;
  logic             ltu_q;

  logic [SW-1:0]    lsb;
  logic             chunk_lt, chunk_eq;
  logic             fin, ltu_fin, eq_fin, neg_fin;

  // Chunk 0 is the most-significant slice.
  assign lsb = SW'((NCHUNK - 1 - 32'(idx_q)) * CHUNK);

  slt_chunk_cmp #(
    .CHUNK (CHUNK)
  ) u_cmp (
    .a  (a_q[lsb +: CHUNK]),
    .b  (b_q[lsb +: CHUNK]),
    .lt (chunk_lt),
    .eq (chunk_eq)
  );

  always_comb begin
    fin     = 1'b0;
    ltu_fin = 1'b0;
    eq_fin  = 1'b0;
    if (EARLY_EXIT != 0 && !chunk_eq) begin
      fin     = 1'b1;
      ltu_fin = chunk_lt;
    end else if (idx_q == LAST_IDX) begin
      fin     = 1'b1;
      ltu_fin = dec_q ? ltu_q : chunk_lt;
      eq_fin  = !dec_q && chunk_eq;
    end
  end

  // Differing signs invert the unsigned order, so one comparator serves both modes.
  assign neg_fin = ltu_fin ^ (a_q[WIDTH-1] ^ b_q[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      aluc_q   <= 1'b0;
      idx_q    <= '0;
      dec_q    <= 1'b0;
      ltu_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      c        <= '0;
      carry    <= 1'b0;
      negative <= 1'b0;
      equal    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            aluc_q  <= aluc;
            idx_q   <= '0;
            dec_q   <= 1'b0;
            ltu_q   <= 1'b0;
            busy    <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (fin) begin
            carry    <= ltu_fin;
            negative <= neg_fin;
            equal    <= eq_fin;
            c        <= WIDTH'((aluc_q == ALUC_SLT) ? neg_fin : ltu_fin);
            done     <= 1'b1;
            busy     <= 1'b0;
            state_q  <= IDLE;
          end else begin
            // Only the first unequal chunk decides in fixed-latency mode.
            if (!chunk_eq && !dec_q) begin
              dec_q <= 1'b1;
              ltu_q <= chunk_lt;
            end
            idx_q <= idx_q + IW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slt_seq.sv
// Directed bench for slt_seq: one early-exit instance and one fixed-latency instance.
module tb_slt_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_e = 1'b0;
  logic        start_f = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        aluc = 1'b0;

  logic        busy_e, done_e, carry_e, negative_e, equal_e;
  logic [31:0] c_e;
  logic        busy_f, done_f, carry_f, negative_f, equal_f;
  logic [31:0] c_f;

  int passed = 0;
  int total  = 0;
  int lat;
  logic [31:0] rc;
  logic        rcarry, rneg, req;

  always #5 clk = ~clk;

  slt_seq #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start_e), .a(a), .b(b), .aluc(aluc),
    .busy(busy_e), .done(done_e), .c(c_e), .carry(carry_e), .negative(negative_e),
    .equal(equal_e)
  );

  slt_seq #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(0)) dut_fx (
    .clk(clk), .rst_n(rst_n), .start(start_f), .a(a), .b(b), .aluc(aluc),
    .busy(busy_f), .done(done_f), .c(c_f), .carry(carry_f), .negative(negative_f),
    .equal(equal_f)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Start one op on the chosen instance and count edges until its done pulse.
  task automatic run(input bit fx, input logic [31:0] aa, input logic [31:0] bb,
                     input logic al, output int l);
    a = aa; b = bb; aluc = al;
    if (fx) start_f = 1'b1; else start_e = 1'b1;
    @(posedge clk); #1;
    start_e = 1'b0; start_f = 1'b0;
    l = 99;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (fx ? done_f : done_e) begin
        l = n;
        break;
      end
    end
    rc     = fx ? c_f : c_e;
    rcarry = fx ? carry_f : carry_e;
    rneg   = fx ? negative_f : negative_e;
    req    = fx ? equal_f : equal_e;
  endtask

  initial begin
    #12;
    check("rst_busy", {31'd0, busy_e}, 32'd0);
    check("rst_done", {31'd0, done_e}, 32'd0);
    check("rst_c", c_e, 32'd0);
    check("rst_flags", {29'd0, carry_e, negative_e, equal_e}, 32'd0);
    check("rst_fx_busy", {31'd0, busy_f}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: signed -1 < 1, early exit at chunk 0
    run(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, lat);
    check("t1_lat", lat, 1);
    check("t1_c", rc, 32'd1);
    check("t1_flags", {29'd0, rcarry, rneg, req}, 32'b010);
    @(posedge clk); #1;
    check("t1_done_pulse", {31'd0, done_e}, 32'd0);

    // 1b: same op, fixed latency
    run(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, lat);
    check("t1f_lat", lat, 4);
    check("t1f_c", rc, 32'd1);
    check("t1f_flags", {29'd0, rcarry, rneg, req}, 32'b010);

    // Fixed latency: first differing chunk wins over a later, opposite one
    run(1'b1, 32'h0200_00FF, 32'h0300_0000, 1'b0, lat);
    check("fx_first_lat", lat, 4);
    check("fx_first_c", rc, 32'd1);
    check("fx_first_flags", {29'd0, rcarry, rneg, req}, 32'b110);

    // 2: unsigned FFFFFFFF vs 1
    run(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
    check("t2_lat", lat, 1);
    check("t2_c", rc, 32'd0);
    check("t2_flags", {29'd0, rcarry, rneg, req}, 32'b010);

    // 3: equal operands take full latency
    run(1'b0, 32'h1234_5678, 32'h1234_5678, 1'b1, lat);
    check("t3_lat", lat, 4);
    check("t3_c", rc, 32'd0);
    check("t3_flags", {29'd0, rcarry, rneg, req}, 32'b001);

    // 4: difference only in the last chunk
    run(1'b0, 32'h0000_0010, 32'h0000_0011, 1'b0, lat);
    check("t4_lat", lat, 4);
    check("t4_c", rc, 32'd1);
    check("t4_flags", {29'd0, rcarry, rneg, req}, 32'b110);

    // 5: start while busy is ignored; start in the done cycle is accepted
    a = 32'd5; b = 32'd9; aluc = 1'b1; start_e = 1'b1;
    @(posedge clk); #1;
    start_e = 1'b0;
    @(posedge clk); #1;
    check("t5_busy", {31'd0, busy_e}, 32'd1);
    a = 32'd9; b = 32'd5; start_e = 1'b1;
    @(posedge clk); #1;
    start_e = 1'b0;
    lat = 99;
    for (int n = 3; n <= 20; n++) begin
      @(posedge clk); #1;
      if (done_e) begin
        lat = n;
        break;
      end
    end
    check("t5_lat", lat, 4);
    check("t5_c", c_e, 32'd1);
    a = 32'd9; b = 32'd5; start_e = 1'b1;
    @(posedge clk); #1;
    start_e = 1'b0;
    check("t5_done_pulse", {31'd0, done_e}, 32'd0);
    check("t5_b2b_busy", {31'd0, busy_e}, 32'd1);
    lat = 99;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (done_e) begin
        lat = n;
        break;
      end
    end
    check("t5_b2b_lat", lat, 4);
    check("t5_b2b_c", c_e, 32'd0);
    @(posedge clk); #1;

    // 6: leave nonzero results, then reset mid-run
    run(1'b0, 32'd1, 32'd2, 1'b1, lat);
    check("t6_pre_c", rc, 32'd1);
    a = 32'd1; b = 32'd2; start_e = 1'b1;
    @(posedge clk); #1;
    start_e = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", {31'd0, busy_e}, 32'd0);
    check("t6_rst_c", c_e, 32'd0);
    check("t6_rst_flags", {29'd0, carry_e, negative_e, equal_e}, 32'd0);
    check("t6_rst_done", {31'd0, done_e}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (done_e) lat++;
    end
    check("t6_no_done", lat, 0);
    run(1'b0, 32'd1, 32'd2, 1'b1, lat);
    check("t6_after_lat", lat, 4);
    check("t6_after_c", rc, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
